imem_loader: RTL and testbench

- Controller-side initiator that drives the instruction-memory write port of the fetch block (cntlr_wr / cntlr_waddr / cntlr_wr_data).
- Accepts a byte stream from the host/debug link over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes words to sequential instruction-memory addresses starting at a programmed base address.
- Signals completion and returns an XOR checksum of all words written.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port between the loader and its environment.
// The master side (the loader) consumes the stream and drives the memory write strobe.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  cntlr_wr;
  logic [ADDR_WIDTH-1:0] cntlr_waddr;
  logic [DATA_WIDTH-1:0] cntlr_wr_data;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output cntlr_wr,
    output cntlr_waddr,
    output cntlr_wr_data
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  cntlr_wr,
    input  cntlr_waddr,
    input  cntlr_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words and writes them
// to consecutive word addresses from a latched base, returning an XOR checksum of the words.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  imem_loader_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           part_q, part_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic [DATA_WIDTH-1:0] word;

  // The fourth byte lands directly in the top lane; only the lower three are buffered.
  assign word = {bus.in_data, part_q};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    part_d     = part_q;
    wr_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    checksum_d = checksum_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          checksum_d = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          part_d     = '0;
          state_d    = (word_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (byte_idx_q == 2'd3) begin
            wr_d       = 1'b1;
            waddr_d    = base_q + word_idx_q[ADDR_WIDTH-1:0];
            wdata_d    = word;
            checksum_d = checksum_q ^ word;
            word_idx_d = word_idx_q + 1'b1;
            byte_idx_d = '0;
            if (word_idx_d == count_q) state_d = StDone;
          end else begin
            part_d[8*byte_idx_q +: 8] = bus.in_data;
            byte_idx_d                = byte_idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      part_q     <= '0;
      wr_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      part_q     <= part_d;
      wr_q       <= wr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      checksum_q <= checksum_d;
    end
  end

  assign bus.in_ready      = (state_q == StLoad);
  assign bus.cntlr_wr      = wr_q;
  assign bus.cntlr_waddr   = waddr_q;
  assign bus.cntlr_wr_data = wdata_q;
  assign busy              = (state_q != StIdle);
  assign done              = (state_q == StDone);
  assign checksum          = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of load descriptors with hand-computed writes and
// checksums, plus hand-written reset sequences.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  imem_loader_if bus ();

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]       base;
    logic [11:0]       count;
    logic [2:0][31:0]  w;
    bit                gaps;
    bit                restart;
    logic [2:0][10:0]  ea;
    logic [31:0]       cks;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Write/done monitor; only grows, loads compare against snapshots.
  logic [10:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  int          done_wr  = 0;
  int          rdy_cyc  = 0;

  always @(negedge clk) begin
    if (bus.cntlr_wr) begin
      wa_q.push_back(bus.cntlr_waddr);
      wd_q.push_back(bus.cntlr_wr_data);
    end
    if (done) begin
      done_cnt++;
      if (bus.cntlr_wr) done_wr++;
    end
    if (bus.in_ready) rdy_cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [10:0] base, input logic [11:0] count,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input bit gaps, input bit restart,
                              input logic [10:0] a0, input logic [10:0] a1,
                              input logic [10:0] a2, input logic [31:0] cks);
    vec_t v;
    v.base    = base;
    v.count   = count;
    v.w[0]    = w0;
    v.w[1]    = w1;
    v.w[2]    = w2;
    v.gaps    = gaps;
    v.restart = restart;
    v.ea[0]   = a0;
    v.ea[1]   = a1;
    v.ea[2]   = a2;
    v.cks     = cks;
    return v;
  endfunction

  task automatic run_load(input vec_t v, input string tag);
    int          b;
    int          cyc;
    int          n0;
    int          d0;
    int          dw0;
    int          r0;
    int          nbytes;
    bit          acc;
    logic [31:0] wtmp;
    n0  = wa_q.size();
    d0  = done_cnt;
    dw0 = done_wr;
    r0  = rdy_cyc;
    @(negedge clk);
    base_addr  = v.base;
    word_count = v.count;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    nbytes = 4 * int'(v.count);
    b      = 0;
    cyc    = 0;
    while (b < nbytes && cyc < 400) begin
      bus.in_valid = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bus.in_valid) begin
        wtmp        = v.w[b / 4];
        bus.in_data = wtmp[8*(b % 4) +: 8];
      end else begin
        bus.in_data = 8'($urandom);
      end
      if (v.restart && b == 6) begin
        start      = 1'b1;
        base_addr  = 11'h300;
        word_count = 12'd1;
      end else begin
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
      end
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) b++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    if (cyc >= 400) check({tag, " stream timeout"}, 32'(b), 32'(nbytes));
    cyc = 0;
    while (done_cnt == d0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, " write count"}, 32'(wa_q.size() - n0), 32'(v.count));
    for (int i = 0; i < int'(v.count) && i < 3; i++) begin
      if (n0 + i < wa_q.size()) begin
        check($sformatf("%s addr%0d", tag, i), 32'(wa_q[n0+i]), 32'(v.ea[i]));
        check($sformatf("%s data%0d", tag, i), wd_q[n0+i], v.w[i]);
      end
    end
    if (v.count != 0) check({tag, " done with last write"}, 32'(done_wr - dw0), 32'd1);
    else              check({tag, " in_ready cycles"}, 32'(rdy_cyc - r0), 32'd0);
    check({tag, " checksum"}, checksum, v.cks);
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, " cntlr_wr"}, 32'(bus.cntlr_wr), 32'd0);
    check({tag, " cntlr_waddr"}, 32'(bus.cntlr_waddr), 32'd0);
    check({tag, " cntlr_wr_data"}, bus.cntlr_wr_data, 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " checksum"}, checksum, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int n_before;
    vecs[0] = mk(11'h010, 12'd2, 32'h00000013, 32'h00100093, 32'h0, 1'b0, 1'b0,
                 11'h010, 11'h011, 11'h0, 32'h00100080);
    vecs[1] = mk(11'h7FF, 12'd2, 32'hDEADBEEF, 32'h12345678, 32'h0, 1'b0, 1'b0,
                 11'h7FF, 11'h000, 11'h0, 32'hCC99E897);
    vecs[2] = mk(11'h100, 12'd3, 32'h11223344, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0,
                 11'h100, 11'h101, 11'h102, 32'hBB8899EE);
    vecs[3] = mk(11'h100, 12'd3, 32'h11223344, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 1'b0,
                 11'h100, 11'h101, 11'h102, 32'hBB8899EE);
    vecs[4] = mk(11'h005, 12'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                 11'h0, 11'h0, 11'h0, 32'h0);
    vecs[5] = mk(11'h020, 12'd2, 32'h0000A001, 32'h0000B002, 32'h0, 1'b0, 1'b1,
                 11'h020, 11'h021, 11'h0, 32'h00001003);
    vecs[6] = mk(11'h7FE, 12'd3, 32'h00000001, 32'h00000002, 32'h00000004, 1'b1, 1'b0,
                 11'h7FE, 11'h7FF, 11'h000, 32'h00000007);

    rst_n        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    word_count   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    // Reset two bytes into a word: outputs clear at once and the word is never written.
    n_before = wa_q.size();
    @(negedge clk);
    base_addr  = 11'h040;
    word_count = 12'd1;
    start      = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    @(negedge clk);
    bus.in_data  = 8'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midload in_ready before reset", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("midload reset");
    @(negedge clk);
    @(negedge clk);
    check("midload no write", 32'(wa_q.size() - n_before), 32'd0);
    rst_n = 1'b1;
    run_load(mk(11'h040, 12'd1, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1'b0,
                11'h040, 11'h0, 11'h0, 32'hCAFEF00D), "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
